// File: rtl/riscv_aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_aes_pkg
// Brief    : Shared AES key-schedule definitions: FSM state type, round
//            count and the Rcon round-constant table.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_aes_pkg;

  // Number of round keys produced after the initial cipher key (AES-128)
  localparam int AES_NUM_ROUNDS = 10;

  // Key expansion controller states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } aes_state_e;

  // Round constants for rounds 1..10; entry k-1 belongs to round k
  localparam logic [7:0] c_rcon [AES_NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Rcon for the round key being produced; zero outside 1..10
  function automatic logic [7:0] aes_rcon(input logic [3:0] round);
    logic [7:0] v;
    v = 8'h00;
    for (int k = 1; k <= AES_NUM_ROUNDS; k++) begin
      if (round == 4'(k)) v = c_rcon[k-1];
    end
    return v;
  endfunction

endpackage : riscv_aes_pkg
`default_nettype wire

// File: rtl/riscv_aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : riscv_aes_sbox
// Brief    : Combinational FIPS-197 forward S-box, one byte in, one byte out.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Table packed with entry 0x00 in the most significant byte
  localparam logic [2047:0] c_sbox_table = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n starts at bit 2047-8n = {~n, 3'b111}
  assign out_o = c_sbox_table[{~in_i, 3'b111} -: 8];

endmodule : riscv_aes_sbox
`default_nettype wire

// File: rtl/riscv_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : riscv_aes_key_expand
// Brief    : AES-128 key schedule. Emits round keys 0..10 one per
//            valid/ready handshake, computing each next key on the fly.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_aes_key_expand
  import riscv_aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   key_w0_i,
  input  logic [DATA_WIDTH-1:0]   key_w1_i,
  input  logic [DATA_WIDTH-1:0]   key_w2_i,
  input  logic [DATA_WIDTH-1:0]   key_w3_i,
  input  logic                    start_i,
  input  logic                    clear_i,
  output logic [4*DATA_WIDTH-1:0] rk_o,
  output logic [3:0]              rk_idx_o,
  output logic                    rk_valid_o,
  input  logic                    rk_ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  // Index of the final round key
  localparam logic [3:0] c_last_idx = 4'(NUM_ROUNDS);

  aes_state_e              r_state;
  logic [4*DATA_WIDTH-1:0] r_rk;
  logic [3:0]              r_idx;
  logic                    r_done;

  logic [DATA_WIDTH-1:0]   w_w0, w_w1, w_w2, w_w3;
  logic [DATA_WIDTH-1:0]   w_rot, w_sub, w_t;
  logic [DATA_WIDTH-1:0]   w_n0, w_n1, w_n2, w_n3;
  logic [7:0]              w_rcon;
  logic                    w_handshake;

  assign w_w0 = r_rk[4*DATA_WIDTH-1:3*DATA_WIDTH];
  assign w_w1 = r_rk[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign w_w2 = r_rk[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_w3 = r_rk[DATA_WIDTH-1:0];

  // RotWord: rotate left by one byte
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  // SubWord: one S-box per byte
  for (genvar i = 0; i < 4; i++) begin : g_subword
    riscv_aes_sbox u_sbox (
      .in_i  (w_rot[8*i +: 8]),
      .out_o (w_sub[8*i +: 8])
    );
  end

  // Rcon is chosen by the index of the key being produced
  assign w_rcon = aes_rcon(r_idx + 4'd1);
  assign w_t    = w_sub ^ {w_rcon, 24'h000000};
  assign w_n0   = w_w0 ^ w_t;
  assign w_n1   = w_w1 ^ w_n0;
  assign w_n2   = w_w2 ^ w_n1;
  assign w_n3   = w_w3 ^ w_n2;

  assign w_handshake = (r_state == ST_RUN) && rk_ready_i;

  // Controller: load on start, advance on handshake, abort on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rk    <= '0;
      r_idx   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clear_i) begin
        r_state <= ST_IDLE;
        r_idx   <= 4'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              r_rk    <= {key_w0_i, key_w1_i, key_w2_i, key_w3_i};
              r_idx   <= 4'd0;
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_handshake) begin
              if (r_idx == c_last_idx) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_rk  <= {w_n0, w_n1, w_n2, w_n3};
                r_idx <= r_idx + 4'd1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rk_o       = r_rk;
  assign rk_idx_o   = r_idx;
  assign done_o     = r_done;
  assign rk_valid_o = (r_state == ST_RUN);
  assign busy_o     = (r_state == ST_RUN);

endmodule : riscv_aes_key_expand
`default_nettype wire

// File: tb/tb_riscv_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_aes_key_expand
// Brief    : Self-checking bench for riscv_aes_key_expand using known-answer
//            round-key tables and an expected-key queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_aes_key_expand;

  logic         clk;
  logic         rst_n;
  logic [31:0]  key_w0, key_w1, key_w2, key_w3;
  logic         start, clear, rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_valid, busy, done;

  riscv_aes_key_expand #(.NUM_ROUNDS(10), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_w0_i   (key_w0),
    .key_w1_i   (key_w1),
    .key_w2_i   (key_w2),
    .key_w3_i   (key_w3),
    .start_i    (start),
    .clear_i    (clear),
    .rk_o       (rk),
    .rk_idx_o   (rk_idx),
    .rk_valid_o (rk_valid),
    .rk_ready_i (rk_ready),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] rk [11];
    int           nk;      // how many leading round keys are known
  } vec_t;

  typedef struct {
    int vec;
    bit rnd;
  } row_t;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
    bit           known;
  } exp_t;

  vec_t vecs [2];
  row_t rows [3];
  exp_t sb [$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive the start pulse at the current falling edge and queue the keys
  task automatic begin_run(input int v);
    logic [127:0] k;
    k = vecs[v].rk[0];
    key_w0 = k[127:96]; key_w1 = k[95:64]; key_w2 = k[63:32]; key_w3 = k[31:0];
    start  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      exp_t e;
      e.idx = 4'(i); e.rk = vecs[v].rk[i]; e.known = (i < vecs[v].nk);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", {127'd0, rk_valid}, 128'd1);
    chk("first_idx",   {124'd0, rk_idx},   128'd0);
    chk("first_key",   rk, vecs[v].rk[0]);
    chk("first_done",  {127'd0, done},     128'd0);
  endtask

  // Consume round keys; returns at a falling edge, either at stop_idx
  // (before its handshake) or one cycle after the last handshake.
  task automatic drain_run(input bit rnd, input int disturb_at, input int stop_idx,
                           output bit stopped);
    int hs, cyc;
    bit prev_stall;
    logic [127:0] prev_rk;
    logic [3:0]   prev_idx;
    hs = 0; cyc = 0; prev_stall = 0; stopped = 0;
    prev_rk = '0; prev_idx = '0;
    while (hs < 11 && cyc < 400) begin
      if (stop_idx >= 0 && rk_valid && rk_idx == 4'(stop_idx)) begin
        stopped = 1;
        return;
      end
      chk("run_valid", {127'd0, rk_valid}, 128'd1);
      if (prev_stall) begin
        chk("stall_key", rk, prev_rk);
        chk("stall_idx", {124'd0, rk_idx}, {124'd0, prev_idx});
      end
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hs == disturb_at) begin
        start  = 1'b1;
        key_w0 = 32'hdeadbeef; key_w1 = 32'h01234567;
        key_w2 = 32'h89abcdef; key_w3 = 32'h55aa55aa;
      end else begin
        start = 1'b0;
      end
      if (rk_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: got handshake idx %0d expected none", rk_idx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hs_idx", {124'd0, rk_idx}, {124'd0, e.idx});
          if (e.known) chk("hs_key", rk, e.rk);
        end
        hs++;
      end
      prev_stall = !rk_ready;
      prev_rk = rk; prev_idx = rk_idx;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (hs < 11) begin
      total++; bad++;
      $display("FAIL run_timeout: got %0d handshakes expected 11", hs);
    end
    if (!rnd) chk("valid_cycles", 128'(cyc), 128'd11);
    chk("end_valid", {127'd0, rk_valid}, 128'd0);
    chk("end_busy",  {127'd0, busy},     128'd0);
    chk("end_done",  {127'd0, done},     128'd1);
    chk("end_sb",    128'(sb.size()),    128'd0);
  endtask

  initial begin
    bit stopped;

    vecs[0].nk = 11;
    vecs[0].rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[0].rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    vecs[0].rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    vecs[0].rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    vecs[0].rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    vecs[0].rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    vecs[0].rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    vecs[0].rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    vecs[0].rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    vecs[0].rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    vecs[0].rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vecs[1].nk = 3;
    for (int i = 0; i < 11; i++) vecs[1].rk[i] = '0;
    vecs[1].rk[1]  = 128'h62636363626363636263636362636363;
    vecs[1].rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

    rows[0] = '{vec: 0, rnd: 1'b0};
    rows[1] = '{vec: 0, rnd: 1'b1};
    rows[2] = '{vec: 1, rnd: 1'b0};

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; rk_ready = 1'b0;
    key_w0 = '0; key_w1 = '0; key_w2 = '0; key_w3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_key",   rk,                 128'd0);
    chk("rst_idx",   {124'd0, rk_idx},   128'd0);
    chk("rst_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_busy",  {127'd0, busy},     128'd0);
    chk("rst_done",  {127'd0, done},     128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven full expansions
    foreach (rows[r]) begin
      begin_run(rows[r].vec);
      drain_run(rows[r].rnd, -1, -1, stopped);
      @(negedge clk);
      chk("done_pulse_1cyc", {127'd0, done}, 128'd0);
    end

    // Start pulsed while busy with another key is ignored
    begin_run(0);
    drain_run(1'b0, 2, -1, stopped);
    // Start in the done cycle launches a new expansion
    begin_run(1);
    drain_run(1'b0, -1, -1, stopped);
    @(negedge clk);
    chk("done_pulse_chain", {127'd0, done}, 128'd0);

    // Clear at idx 5, asserted together with start and handshake
    begin_run(0);
    drain_run(1'b0, -1, 5, stopped);
    chk("clear_reached", {127'd0, stopped}, 128'd1);
    clear = 1'b1; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    sb.delete();
    chk("clear_valid", {127'd0, rk_valid}, 128'd0);
    chk("clear_busy",  {127'd0, busy},     128'd0);
    chk("clear_idx",   {124'd0, rk_idx},   128'd0);
    chk("clear_done",  {127'd0, done},     128'd0);
    @(negedge clk);
    chk("clear_done2", {127'd0, done},     128'd0);
    chk("clear_idle",  {127'd0, rk_valid}, 128'd0);
    begin_run(1);
    drain_run(1'b0, -1, -1, stopped);
    @(negedge clk);

    // Asynchronous reset at idx 3
    begin_run(0);
    drain_run(1'b0, -1, 3, stopped);
    chk("reset_reached", {127'd0, stopped}, 128'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_key",   rk,                 128'd0);
    chk("arst_idx",   {124'd0, rk_idx},   128'd0);
    chk("arst_valid", {127'd0, rk_valid}, 128'd0);
    chk("arst_busy",  {127'd0, busy},     128'd0);
    chk("arst_done",  {127'd0, done},     128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", {127'd0, done},     128'd0);
      chk("arst_idle",    {127'd0, rk_valid}, 128'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_riscv_aes_key_expand
`default_nettype wire
